pool_relu_layer_2: RTL and testbench

- Streaming 2x2 max-pool (stride 2) plus ReLU stage directly downstream of the second convolution layer.
- Consumes the 2-channel 10x10 conv-2 feature map one pixel position per beat, in raster order, with both channels side by side.
- Emits the 2-channel 5x5 pooled map, also in raster order, which feeds the flatten/fully-connected stage.
- Uses a half-width line buffer, so a full-frame buffer is never held.

---
 rtl/pool_relu_layer_2.sv | 154 +++++++++++++++
 tb/tb_pool_relu_layer_2.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_relu_layer_2.sv
// rtl/pool_relu_layer_2.sv - streaming 2x2 stride-2 max-pool plus ReLU for the conv-2 feature map
//
// Accepts one pixel position per beat in raster order, with all channels packed side by side,
// and emits the pooled map in raster order. Only half a row of partial maxima is ever buffered.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready = !out_valid || out_ready
//   in_data, in_last     packed signed samples (channel 0 in LSBs), end-of-frame marker
//   out_valid/out_ready  output handshake
//   out_data, out_last   pooled samples (same packing), final pooled pixel of frame
//   frame_err            sticky: in_last seen at the wrong position or missing at the end

module pool_relu_layer_2 #(
  parameter int BITWIDTH = 8,
  parameter int CHANNELS = 2,
  parameter int IN_DIM   = 10,
  parameter int RELU_EN  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BITWIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*BITWIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         frame_err
);

  localparam int DW   = CHANNELS * BITWIDTH;
  localparam int CW   = $clog2(IN_DIM);
  localparam int LW   = CW - 1;           // index width into the half-width line buffer
  localparam int HALF = IN_DIM / 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(IN_DIM - 1);

  logic [CW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_q, col_d;
  logic [DW-1:0]            hold_q, hold_d;
  logic [HALF-1:0][DW-1:0]  lb_q, lb_d;
  logic                     out_valid_q, out_valid_d;
  logic [DW-1:0]            out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic                     frame_err_q, frame_err_d;

  logic                     accept;
  logic                     at_end;
  logic [LW-1:0]            lb_idx;
  logic [DW-1:0]            lb_sel;
  logic signed [BITWIDTH-1:0] px, hv, lv, res;

  function automatic logic signed [BITWIDTH-1:0] smax(input logic signed [BITWIDTH-1:0] a,
                                                      input logic signed [BITWIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Never overwrites a stalled result: when in_ready is high the output slot is free or draining.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign at_end   = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign lb_idx   = col_q[CW-1:1];

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    hold_d      = hold_q;
    lb_d        = lb_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_err_d = frame_err_q;
    lb_sel      = lb_q[lb_idx];
    px          = '0;
    hv          = '0;
    lv          = '0;
    res         = '0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      // Early in_last resynchronises the frame so the next beat is (0,0).
      if (in_last && !at_end) begin
        row_d       = '0;
        col_d       = '0;
        frame_err_d = 1'b1;
      end else if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (at_end && !in_last) begin
        frame_err_d = 1'b1;
      end

      for (int ch = 0; ch < CHANNELS; ch++) begin
        px = in_data[ch*BITWIDTH +: BITWIDTH];
        hv = hold_q[ch*BITWIDTH +: BITWIDTH];
        lv = lb_sel[ch*BITWIDTH +: BITWIDTH];
        case ({row_q[0], col_q[0]})
          2'b00: hold_d[ch*BITWIDTH +: BITWIDTH] = px;
          2'b01: lb_d[lb_idx][ch*BITWIDTH +: BITWIDTH] = smax(hv, px);
          2'b10: hold_d[ch*BITWIDTH +: BITWIDTH] = smax(lv, px);
          default: begin
            res = smax(hv, px);
            if ((RELU_EN != 0) && res[BITWIDTH-1]) begin
              res = '0;
            end
            out_data_d[ch*BITWIDTH +: BITWIDTH] = res;
          end
        endcase
      end

      // A new result takes priority over the clear from a simultaneous output transfer.
      if (row_q[0] && col_q[0]) begin
        out_valid_d = 1'b1;
        out_last_d  = at_end;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      hold_q      <= '0;
      lb_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      hold_q      <= hold_d;
      lb_q        <= lb_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_pool_relu_layer_2.sv
// tb/tb_pool_relu_layer_2.sv - scoreboard bench for pool_relu_layer_2 (ReLU on and off instances)
//
// Two instances share the input stream and out_ready: u_a with RELU_EN=1, u_b with RELU_EN=0.
// Expected pooled pixels are computed from a full-frame copy of the driven pixels.

module tb_pool_relu_layer_2;

  localparam int BW  = 8;
  localparam int CH  = 2;
  localparam int DIM = 10;
  localparam int DW  = CH * BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;

  logic          in_ready_a, out_valid_a, out_last_a, frame_err_a;
  logic [DW-1:0] out_data_a;
  logic          in_ready_b, out_valid_b, out_last_b, frame_err_b;
  logic [DW-1:0] out_data_b;

  pool_relu_layer_2 #(.BITWIDTH(BW), .CHANNELS(CH), .IN_DIM(DIM), .RELU_EN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .frame_err(frame_err_a)
  );

  pool_relu_layer_2 #(.BITWIDTH(BW), .CHANNELS(CH), .IN_DIM(DIM), .RELU_EN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .frame_err(frame_err_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] frame_px [DIM][DIM];
  int            m_row = 0;
  int            m_col = 0;
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  logic          q_last[$];

  int            n_out = 0;
  int            n_last = 0;
  logic [DW-1:0] first_a, last_a, first_b, last_b;
  int            ready_mode = 0;  // 0: always ready, 1: random 50%, 2: held low

  function automatic logic [DW-1:0] pool(input int r, input int c, input bit relu);
    logic [DW-1:0]        res;
    logic signed [BW-1:0] m;
    logic signed [BW-1:0] v;
    res = '0;
    for (int ch = 0; ch < CH; ch++) begin
      m = frame_px[r-1][c-1][ch*BW +: BW];
      for (int k = 1; k < 4; k++) begin
        v = frame_px[r-1+k/2][c-1+k%2][ch*BW +: BW];
        if (v > m) m = v;
      end
      if (relu && m < 0) m = '0;
      res[ch*BW +: BW] = m;
    end
    return res;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input bit last);
    bit at_end;
    at_end = (m_row == DIM-1) && (m_col == DIM-1);
    frame_px[m_row][m_col] = d;
    if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
      q_a.push_back(pool(m_row, m_col, 1'b1));
      q_b.push_back(pool(m_row, m_col, 1'b0));
      q_last.push_back(at_end);
    end
    if (last && !at_end) begin
      m_row = 0;
      m_col = 0;
    end else if (m_col == DIM-1) begin
      m_col = 0;
      m_row = (m_row == DIM-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor at the falling edge, where inputs and outputs are settled.
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_hold_data", out_data_a, prev_data);
        check("stall_hold_last", out_last_a, prev_last);
      end
      if (out_valid_a && !out_ready) check("in_ready_low_on_stall", in_ready_a, 0);
      if (out_valid_a && out_ready) begin
        if (q_a.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [DW-1:0] ea, eb;
          logic          el;
          ea = q_a.pop_front();
          eb = q_b.pop_front();
          el = q_last.pop_front();
          check("relu_data", out_data_a, ea);
          check("raw_data", out_data_b, eb);
          check("out_last", out_last_a, el);
          check("raw_valid", out_valid_b, 1);
          check("raw_last", out_last_b, el);
        end
        if (n_out == 0) begin
          first_a = out_data_a;
          first_b = out_data_b;
        end
        last_a = out_data_a;
        last_b = out_data_b;
        n_out++;
        if (out_last_a) n_last++;
      end
      prev_stall = out_valid_a && !out_ready;
      prev_data  = out_data_a;
      prev_last  = out_last_a;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input bit last);
    int t;
    bit took;
    t = 0;
    took = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!took) begin
      @(negedge clk);
      took = in_ready_a && in_ready_b;
      @(posedge clk);
      #1;
      if (!took) begin
        t++;
        if (t > 300) begin
          check("in_ready_timeout", 0, 1);
          break;
        end
      end
    end
    if (took) model_accept(d, last);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // kind 0: ramp (ch0 = v, ch1 = -v); kind 1: random samples
  task automatic send_frame(input int kind, input int nbeats, input int last_beat, input bit gaps);
    logic [DW-1:0] d;
    logic [BW-1:0] v;
    for (int i = 0; i < nbeats; i++) begin
      v = BW'((i / DIM) * 10 + (i % DIM));
      if (kind == 0) d = {BW'(-v), v};
      else           d = DW'($urandom);
      send_beat(d, (i + 1) == last_beat);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (q_a.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check(tag, q_a.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid_a, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    q_a.delete();
    q_b.delete();
    q_last.delete();
    m_row = 0;
    m_col = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_out_last", out_last_a, 0);
    check("rst_frame_err", frame_err_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame, no stalls
    n_out = 0; n_last = 0;
    send_frame(0, 100, 100, 1'b0);
    drain("ramp_drain");
    check("ramp_count", n_out, 25);
    check("ramp_last_count", n_last, 1);
    check("ramp_first_ch0", first_a[7:0], 8'd11);
    check("ramp_last_ch0", last_a[7:0], 8'd99);
    check("ramp_last_ch1_relu", last_a[15:8], 8'd0);
    check("raw_first_ch1", first_b[15:8], 8'd0);
    check("raw_last_ch1", last_b[15:8], 8'hA8);
    check("ramp_frame_err", frame_err_a, 0);

    // Ramp and random frames with random stalls and input gaps
    ready_mode = 1;
    n_out = 0; n_last = 0;
    send_frame(0, 100, 100, 1'b1);
    drain("stall_ramp_drain");
    check("stall_ramp_count", n_out, 25);
    check("stall_ramp_last", last_a[7:0], 8'd99);
    n_out = 0; n_last = 0;
    send_frame(1, 100, 100, 1'b1);
    send_frame(1, 100, 100, 1'b0);
    drain("stall_rand_drain");
    check("stall_rand_count", n_out, 50);
    check("stall_rand_last_count", n_last, 2);
    check("stall_frame_err", frame_err_b, 0);

    // Early in_last on beat 50, then a good frame
    ready_mode = 0;
    n_out = 0; n_last = 0;
    send_frame(0, 50, 50, 1'b0);
    check("early_last_err", frame_err_a, 1);
    check("early_last_err_b", frame_err_b, 1);
    drain("early_drain");
    check("early_count", n_out, 10);
    check("early_no_last", n_last, 0);
    n_out = 0; n_last = 0;
    send_frame(0, 100, 100, 1'b0);
    drain("resync_drain");
    check("resync_count", n_out, 25);
    check("resync_last", n_last, 1);
    check("resync_first_ch0", first_a[7:0], 8'd11);

    // Missing in_last at the end of the frame
    apply_reset();
    check("err_cleared", frame_err_a, 0);
    n_out = 0; n_last = 0;
    send_frame(0, 100, 0, 1'b0);
    check("missing_last_err", frame_err_a, 1);
    drain("missing_drain");
    check("missing_count", n_out, 25);

    // Reset after beat 37, then reset with a stalled result pending
    apply_reset();
    send_frame(0, 37, 0, 1'b0);
    apply_reset();
    check("midreset_err", frame_err_a, 0);
    send_frame(1, 37, 0, 1'b0);
    ready_mode = 2;
    send_beat(DW'($urandom), 1'b0);
    @(posedge clk);
    #2;
    check("pending_valid", out_valid_a, 1);
    apply_reset();
    check("async_clear_data", out_data_a, 0);
    check("async_clear_last", out_last_a, 0);
    ready_mode = 0;
    n_out = 0; n_last = 0;
    send_frame(0, 100, 100, 1'b0);
    drain("post_reset_drain");
    check("post_reset_count", n_out, 25);
    check("post_reset_first", first_a, 16'h000B);
    check("post_reset_last", last_a[7:0], 8'd99);

    // Two back-to-back frames
    n_out = 0; n_last = 0;
    send_frame(0, 100, 100, 1'b0);
    send_frame(1, 100, 100, 1'b0);
    drain("b2b_drain");
    check("b2b_count", n_out, 50);
    check("b2b_last_count", n_last, 2);
    check("b2b_frame_err", frame_err_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
